// File: rtl/modn_counter_pkg.sv
// rtl/modn_counter_pkg.sv - shared state encodings, width helper and default modulus for modn_counter
package modn_counter_pkg;

  typedef enum logic {
    ST_COUNTING = 1'b0,
    ST_HALTED   = 1'b1
  } state_t;

  localparam int DEFAULT_MODULUS = 100;

  // Smallest r with 2**r >= value; capped at 31 so the shift stays positive.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/modn_wrap_tally.sv
// rtl/modn_wrap_tally.sv - wrap tally register; instantiated only under MODN_WRAP_TALLY_EN
module modn_wrap_tally
  import modn_counter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] tally
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tally <= '0;
    end else if (clear) begin
      tally <= '0;
    end else if (inc) begin
      tally <= tally + WIDTH'(1);
    end
  end

endmodule

// File: rtl/modn_counter.sv
// rtl/modn_counter.sv - modulo-N up/down counter with load, one-shot halt and wrap pulse (option: MODN_WRAP_TALLY_EN)
module modn_counter
  import modn_counter_pkg::*;
#(
  parameter  int MODULUS     = DEFAULT_MODULUS,
  parameter  int TALLY_WIDTH = 8,
  localparam int WIDTH       = clog2(MODULUS)
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             ENABLE,
  input  logic             UP_DOWN,
  input  logic             ONE_SHOT,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LOAD_VALUE,
  output logic [WIDTH-1:0] COUNT,
  output logic             sigN,
  output logic             DONE,
  output logic             LOAD_ERR
`ifdef MODN_WRAP_TALLY_EN
  ,
  output logic [TALLY_WIDTH-1:0] WRAP_TALLY
`endif
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  if (MODULUS < 2 || TALLY_WIDTH < 1) begin : g_param_check
    $error("modn_counter: MODULUS must be >= 2 and TALLY_WIDTH >= 1");
  end

  state_t           state;
  logic             at_top;
  logic             at_bottom;
  logic             wrap;
  logic             load_ok;
  logic [WIDTH-1:0] count_step;

  // Out-of-range counts are unreachable, but if seen they behave as the terminal value.
  always_comb begin
    at_top     = (COUNT >= MAX_VAL);
    at_bottom  = (COUNT == '0) || (COUNT > MAX_VAL);
    wrap       = ENABLE && (state == ST_COUNTING) && (UP_DOWN ? at_top : at_bottom);
    load_ok    = ({1'b0, LOAD_VALUE} < MOD_EXT);
    count_step = COUNT;
    if (UP_DOWN) begin
      count_step = at_top ? '0 : COUNT + WIDTH'(1);
    end else begin
      count_step = at_bottom ? MAX_VAL : COUNT - WIDTH'(1);
    end
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      COUNT    <= '0;
      sigN     <= 1'b0;
      LOAD_ERR <= 1'b0;
      state    <= ST_COUNTING;
    end else if (LOAD) begin
      COUNT    <= load_ok ? LOAD_VALUE : MAX_VAL;
      LOAD_ERR <= !load_ok;
      sigN     <= 1'b0;
      state    <= ST_COUNTING;
    end else if (ENABLE && (state == ST_COUNTING)) begin
      COUNT <= count_step;
      sigN  <= wrap;
      if (wrap && ONE_SHOT) state <= ST_HALTED;
    end else begin
      sigN <= 1'b0;
    end
  end

  assign DONE = (state == ST_HALTED);

`ifdef MODN_WRAP_TALLY_EN
  // LOAD clears the tally and also suppresses the wrap, so clear-over-inc is consistent.
  modn_wrap_tally #(
    .WIDTH(TALLY_WIDTH)
  ) u_wrap_tally (
    .clk  (CLOCK),
    .rst  (RESET),
    .clear(LOAD),
    .inc  (wrap),
    .tally(WRAP_TALLY)
  );
`endif

endmodule
